inst_mem_pipelined: RTL and testbench
=====================================

Name: inst_mem_pipelined

Overview:
Parametrised, synchronous successor to the team's combinational instruction memory. Adds a valid/ready fetch handshake, configurable read latency, word or byte addressing, and a program-load write port. It sits between the multi-cycle control unit's fetch stage and the instruction register, and absorbs fetch-side backpressure without dropping responses.

Parameters:
ADDR_W, 16, request/load address width in bits
DATA_W, 32, instruction width in bits
DEPTH, 1024, number of instruction words; need not be a power of two
LATENCY, 2, cycles from request acceptance to earliest rsp_valid; legal range 1..4
BYTE_ADDR, 0, 0 = address is a word index; 1 = address is a byte address (index = addr >> 2; requires DATA_W = 32)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  fetch address
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  instruction word
rsp_err  out  1  request was out of range or misaligned
load_en  in  1  write load_data into memory this cycle
load_addr  in  ADDR_W  load word index; always word-indexed, independent of BYTE_ADDR
load_data  in  DATA_W  word to write
outstanding  out  $clog2(LATENCY+2)  accepted requests not yet handed off

Behaviour:
- Reset is asynchronous and active-low. clk and rst_n are the only clock and reset.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, outstanding=0. All pipeline valids and FIFO pointers are cleared. Memory array contents are not reset.
- Handshakes:
  - Request accepted on a clk edge where req_valid && req_ready.
  - Response consumed on a clk edge where rsp_valid && rsp_ready.
- Latency: a request accepted at edge t has its response visible on rsp_* after edge t+LATENCY-1, i.e. sampled at edge t+LATENCY, provided no older response is still queued.
- Responses are returned strictly in request order.
- Read pipeline:
  - Stage 0 registers the index and error flag.
  - The array is read in stage 0.
  - Stages 1..LATENCY-1 are delay registers, each carrying data, err and a valid bit.
  - The final stage writes into an output FIFO of depth MAX_OUT = LATENCY+1.
  - rsp_* is driven from the FIFO head.
- Flow control:
  - outstanding = in-flight pipeline entries + FIFO entries.
  - It increments on accept, decrements on consume, and is unchanged when both happen in the same cycle.
  - req_ready = (outstanding != MAX_OUT). It depends only on registered state and never combinationally on rsp_ready or req_valid.
  - With rsp_ready held high this gives one accept per cycle sustained.
- Error rules:
  - index >= DEPTH gives rsp_err=1 and rsp_data=0.
  - BYTE_ADDR=1 with req_addr[1:0] != 0 gives rsp_err=1 and rsp_data=0.
  - An error response still occupies a slot and honours ordering.
- Load port:
  - Writes ram[load_addr] at the edge when load_en=1.
  - load_addr >= DEPTH is ignored.
  - Load is independent of the fetch handshake.
  - A same-cycle load and fetch to the same index returns the old data (read-before-write).
- Backpressure: when rsp_ready=0 the FIFO fills, and req_ready drops once outstanding reaches MAX_OUT. No response is ever lost or duplicated.
- Reset mid-operation: all in-flight and queued responses are discarded. The first request after reset release behaves as from cold.
- Memory is initialised via $readmemh only when a plusarg/file is supplied; otherwise it is left unspecified.

Decomposition:
- Shared package inst_mem_pkg holds:
  - the response struct typedef {data, err};
  - the LATENCY range bounds;
  - the MAX_OUT = LATENCY+1 constant function.
- One natural sub-module: inst_rsp_fifo, a parametrised depth/width synchronous FIFO with full/empty and count, using async active-low reset. The top holds the array, the pipeline and the credit counter.

Test Plan:
1. Load ram[0]=0x2000_0004 and ram[1]=0x1111_1111; LATENCY=2; fetch 0 at edge t and 1 at edge t+1 with rsp_ready=1 -> 0x2000_0004 sampled at t+2 and 0x1111_1111 at t+3, rsp_err=0, req_ready stays 1.
2. Backpressure: LATENCY=2, rsp_ready=0, req_valid held -> exactly 3 requests accepted and req_ready=0 with outstanding=3. Then rsp_ready=1 -> 3 responses returned in order and req_ready reasserts in the cycle after the first consume.
3. Out of range: DEPTH=1024, fetch 1024 then 5 -> first response err=1 with data=0; second is the ram[5] data with err=0, in order.
4. BYTE_ADDR=1: fetch 0x0008 -> ram[2] returned. Fetch 0x0006 -> err=1, data=0.
5. Same-cycle load of ram[3]=0xDEAD_BEEF and fetch 3 -> old ram[3] returned. A following fetch of 3 -> 0xDEAD_BEEF.
6. Assert rst_n=0 asynchronously with 2 requests in flight -> rsp_valid drops immediately, outstanding=0, req_ready=1, and no stale response appears after release.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the pipelined instruction memory.
// Holds the legal read-latency range, the default-width response record and
// the helper that sizes the credit pool / response FIFO from the latency.
package inst_mem_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;
    localparam int INST_W      = 32;

    // Response record at the default instruction width.
    typedef struct packed {
        logic [INST_W-1:0] data;
        logic              err;
    } rsp_t;

    // Number of requests that may be in flight or queued at once.
    function automatic int max_out(input int latency);
        return latency + 1;
    endfunction

endpackage

// File: rtl/inst_rsp_fifo.sv
// Synchronous response FIFO with full/empty flags and occupancy count.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push one entry (ignored while full)
//   rd_en             pop the head entry (ignored while empty)
//   rd_data           head entry, zero after reset
//   full, empty       occupancy flags
//   count             number of stored entries
// DEPTH need not be a power of two; pointers wrap explicitly.
module inst_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 33,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full    = (cnt_r == CNT_W'(DEPTH));
    assign empty   = (cnt_r == '0);
    assign count   = cnt_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign push_s  = wr_en && !full;
    assign pop_s   = rd_en && !empty;

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/inst_mem_pipelined.sv
// Pipelined instruction memory with valid/ready fetch handshake and a
// program-load write port.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr   fetch request handshake and address
//   rsp_valid/rsp_ready            response handshake
//   rsp_data/rsp_err               instruction word, out-of-range/misaligned flag
//   load_en/load_addr/load_data    word-indexed array write
//   outstanding                    accepted requests not yet consumed
// A request accepted at edge t is read from the array in the same cycle,
// walks LATENCY-1 registered stages (the last one being the FIFO write) and
// is visible on rsp_* after edge t+LATENCY-1. A credit counter bounded by
// LATENCY+1 guarantees the response FIFO never overflows.
module inst_mem_pipelined
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter int BYTE_ADDR = 0,
    localparam int OUT_W    = $clog2(LATENCY + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [OUT_W-1:0]  outstanding
);

    localparam int          MAX_OUT = max_out(LATENCY);
    localparam int          PIPE    = LATENCY - 1;
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX ||
            (BYTE_ADDR != 0 && DATA_W != 32)) begin : g_bad_param
            $error("inst_mem_pipelined: illegal LATENCY/BYTE_ADDR/DATA_W combination");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_word_t;

    logic [DATA_W-1:0] ram_r [DEPTH];

    logic [ADDR_W-1:0] idx_s;
    logic              req_err_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [DATA_W-1:0] rd_data_s;
    rsp_word_t         in_rsp_s;
    logic              accept_s;
    logic              consume_s;
    logic              fifo_wr_s;
    rsp_word_t         fifo_wdata_s;
    logic [DATA_W:0]   fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [$clog2(MAX_OUT+1)-1:0] fifo_count_s;
    logic              unused_ok_s;
    logic [OUT_W-1:0]  out_r;
    logic [OUT_W-1:0]  out_next_s;
    logic              ready_r;

    assign accept_s  = req_valid && ready_r;
    assign consume_s = !fifo_empty_s && rsp_ready;

    // Address to word index plus error classification.
    always_comb begin
        idx_s     = req_addr;
        req_err_s = 1'b0;
        if (BYTE_ADDR != 0) begin
            idx_s     = {2'b00, req_addr[ADDR_W-1:2]};
            req_err_s = (req_addr[1:0] != 2'b00);
        end else begin
            idx_s     = req_addr;
            req_err_s = 1'b0;
        end
        if (32'(idx_s) >= DEPTH_U) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = req_err_s;
        end
    end

    // Erroneous requests read a safe index and return zero data.
    always_comb begin
        rd_idx_s  = '0;
        rd_data_s = '0;
        if (req_err_s) begin
            rd_idx_s  = '0;
            rd_data_s = '0;
        end else begin
            rd_idx_s  = idx_s[IDX_W-1:0];
            rd_data_s = ram_r[rd_idx_s];
        end
    end

    assign in_rsp_s = '{data: rd_data_s, err: req_err_s};

    // Program-load write port; the array read above sees the pre-write value.
    always_ff @(posedge clk) begin
        if (load_en && (32'(load_addr) < DEPTH_U)) begin
            ram_r[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign fifo_wr_s    = accept_s;
            assign fifo_wdata_s = in_rsp_s;
        end else begin : g_pipe
            logic [PIPE-1:0] vld_r;
            rsp_word_t       stg_r [PIPE];

            // Delay line from the array read to the response FIFO.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_r <= '0;
                    for (int i = 0; i < PIPE; i++) begin
                        stg_r[i] <= '0;
                    end
                end else begin
                    vld_r[0] <= accept_s;
                    stg_r[0] <= in_rsp_s;
                    for (int i = 1; i < PIPE; i++) begin
                        vld_r[i] <= vld_r[i-1];
                        stg_r[i] <= stg_r[i-1];
                    end
                end
            end

            assign fifo_wr_s    = vld_r[PIPE-1];
            assign fifo_wdata_s = stg_r[PIPE-1];
        end
    endgenerate

    inst_rsp_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr_s),
        .wr_data (fifo_wdata_s),
        .rd_en   (consume_s),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Occupancy is fully tracked by the credit counter; FIFO status is informational.
    assign unused_ok_s = ^{fifo_full_s, fifo_count_s};

    // Credit counter next value: +1 on accept, -1 on consume.
    always_comb begin
        out_next_s = out_r;
        case ({accept_s, consume_s})
            2'b10:   out_next_s = out_r + OUT_W'(1);
            2'b01:   out_next_s = out_r - OUT_W'(1);
            default: out_next_s = out_r;
        endcase
    end

    // Credit counter and registered ready (equal to outstanding != MAX_OUT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= '0;
            ready_r <= 1'b1;
        end else begin
            out_r   <= out_next_s;
            ready_r <= (out_next_s != OUT_W'(MAX_OUT));
        end
    end

    assign req_ready   = ready_r;
    assign outstanding = out_r;
    assign rsp_valid   = !fifo_empty_s;
    assign rsp_data    = fifo_rdata_s[DATA_W:1];
    assign rsp_err     = fifo_rdata_s[0];

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Randomised bench for inst_mem_pipelined: one word-addressed and one
// byte-addressed instance share stimulus; a transaction-level model
// (word array + queue of pending responses with their accept cycle)
// predicts every output each cycle.
module tb_inst_mem_pipelined;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int MAXO  = LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] load_addr = 16'h0;
    logic [31:0] load_data = 32'h0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_data_a;
    logic [1:0]  out_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_data_b;
    logic [1:0]  out_b;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_m [DEPTH];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    inst_mem_pipelined #(.LATENCY(LAT), .DEPTH(DEPTH), .BYTE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_addr(req_addr),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_a), .rsp_err(rsp_err_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .outstanding(out_a)
    );

    inst_mem_pipelined #(.LATENCY(LAT), .DEPTH(DEPTH), .BYTE_ADDR(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_addr(req_addr),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .outstanding(out_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t predict(input logic [15:0] addr, input bit bmode, input int acc);
        exp_t e;
        int   idx;
        idx   = bmode ? (int'(addr) >> 2) : int'(addr);
        e.err = (idx >= DEPTH) || (bmode && (addr[1:0] != 2'b00));
        if (e.err) e.data = 32'h0;
        else       e.data = mem_m[idx];
        e.acc = acc;
        return e;
    endfunction

    task automatic check_side(input string nm, input exp_t q[$], input logic rdy,
                              input logic vld, input logic [31:0] data,
                              input logic err, input logic [1:0] outs);
        bit vis;
        vis = (q.size() > 0) && (q[0].acc + LAT - 1 <= cyc);
        check_eq({nm, "_req_ready"}, 64'(rdy), 64'(q.size() != MAXO));
        check_eq({nm, "_rsp_valid"}, 64'(vld), 64'(vis));
        check_eq({nm, "_outstanding"}, 64'(outs), 64'(q.size()));
        if (vis) begin
            check_eq({nm, "_rsp_data"}, 64'(data), 64'(q[0].data));
            check_eq({nm, "_rsp_err"}, 64'(err), 64'(q[0].err));
        end
    endtask

    // One clock: model reacts to the current inputs, then outputs are checked at the falling edge.
    task automatic step();
        bit   acc_a, acc_b, con_a, con_b;
        exp_t ea, eb;
        acc_a = req_valid && (qa.size() != MAXO);
        acc_b = req_valid && (qb.size() != MAXO);
        con_a = rsp_ready && (qa.size() > 0) && (qa[0].acc + LAT - 1 <= cyc);
        con_b = rsp_ready && (qb.size() > 0) && (qb[0].acc + LAT - 1 <= cyc);
        ea = predict(req_addr, 1'b0, cyc + 1);
        eb = predict(req_addr, 1'b1, cyc + 1);
        @(posedge clk);
        cyc++;
        if (con_a) qa.delete(0);
        if (con_b) qb.delete(0);
        if (acc_a) qa.push_back(ea);
        if (acc_b) qb.push_back(eb);
        if (load_en && (int'(load_addr) < DEPTH)) mem_m[load_addr] = load_data;
        @(negedge clk);
        check_side("a", qa, req_ready_a, rsp_valid_a, rsp_data_a, rsp_err_a, out_a);
        check_side("b", qb, req_ready_b, rsp_valid_b, rsp_data_b, rsp_err_b, out_b);
    endtask

    task automatic do_load(input logic [15:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a);
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check_eq("reset_ready_a", 64'(req_ready_a), 64'd1);
        check_eq("reset_valid_a", 64'(rsp_valid_a), 64'd0);
        check_eq("reset_data_a", 64'(rsp_data_a), 64'd0);
        check_eq("reset_err_a", 64'(rsp_err_a), 64'd0);
        check_eq("reset_out_a", 64'(out_a), 64'd0);
        check_eq("reset_valid_b", 64'(rsp_valid_b), 64'd0);
        check_eq("reset_out_b", 64'(out_b), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_load(16'(i), $urandom);

        // Back-to-back fetches with immediate consumption.
        do_load(16'd0, 32'h2000_0004);
        do_load(16'd1, 32'h1111_1111);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'd0; step();
        req_addr = 16'd1; step();
        req_valid = 1'b0;
        check_eq("t1_first_data", 64'(rsp_data_a), 64'h2000_0004);
        step();
        check_eq("t1_second_data", 64'(rsp_data_a), 64'h1111_1111);
        check_eq("t1_ready_held", 64'(req_ready_a), 64'd1);
        repeat (3) step();

        // Backpressure fills the credit pool.
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_addr = 16'(10 + i);
            step();
        end
        check_eq("t2_out_full", 64'(out_a), 64'd3);
        check_eq("t2_ready_low", 64'(req_ready_a), 64'd0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        check_eq("t2_ready_back", 64'(req_ready_a), 64'd1);
        repeat (4) step();

        // Out of range then in range; byte-address alignment cases.
        fetch(16'd1024);
        fetch(16'd5);
        fetch(16'h0008);
        fetch(16'h0006);
        repeat (4) step();

        // Loads beyond the array are dropped.
        do_load(16'd1024, 32'hBAD0_0000);
        do_load(16'd1027, 32'hBAD0_0003);
        fetch(16'd0);
        fetch(16'd3);
        repeat (4) step();

        // Same-cycle load and fetch reads the old word.
        load_en = 1'b1; load_addr = 16'd3; load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 16'd3;
        step();
        load_en = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check_eq("t5_new_data", 64'(rsp_data_a), 64'hDEAD_BEEF);
        repeat (3) step();

        // Asynchronous reset with requests in flight.
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 16'd1; step();
        req_addr = 16'd2; step();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_valid_a", 64'(rsp_valid_a), 64'd0);
        check_eq("t6_out_a", 64'(out_a), 64'd0);
        check_eq("t6_ready_a", 64'(req_ready_a), 64'd1);
        check_eq("t6_valid_b", 64'(rsp_valid_b), 64'd0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        repeat (4) step();
        fetch(16'd2);
        repeat (3) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       req_addr = 16'($urandom_range(0, 1100));
                1:       req_addr = 16'(4 * $urandom_range(0, 1030));
                2:       req_addr = 16'($urandom);
                default: req_addr = 16'($urandom_range(0, 16));
            endcase
            load_en   = ($urandom_range(0, 7) == 0);
            load_addr = 16'($urandom_range(0, 1100));
            load_data = $urandom;
            step();
        end
        req_valid = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
